// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button reader.
//   btn_state_e : per-button debounce/hold state machine encoding
//   cnt_width() : width of a counter that must hold max(a, b) without overflow
package button_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_LONG_HELD,
      ST_RELEASE_WAIT
   } btn_state_e;

   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      cnt_width = (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_reader_if.sv
// Button bundle between the board-side environment and the button reader.
//   nBtn          : raw active-low buttons (0 = pressed)
//   pressed       : debounced level per button
//   press_pulse   : one-cycle strobe per accepted press
//   release_pulse : one-cycle strobe per accepted release
//   long_pulse    : one-cycle strobe when a press has been held long enough
// master drives the buttons and observes results; slave is the reader.
interface button_reader_if #(
   parameter int num_buttons = 5
);
   logic [num_buttons-1:0] nBtn;
   logic [num_buttons-1:0] pressed;
   logic [num_buttons-1:0] press_pulse;
   logic [num_buttons-1:0] release_pulse;
   logic [num_buttons-1:0] long_pulse;

   modport master (
      output nBtn,
      input  pressed, press_pulse, release_pulse, long_pulse
   );

   modport slave (
      input  nBtn,
      output pressed, press_pulse, release_pulse, long_pulse
   );
endinterface

// File: rtl/button_debounce.sv
// Single-button synchronizer, debounce FSM and long-press detector.
//   clk, rst      : system clock, synchronous active-high reset
//   tick          : one-cycle 1 ms strobe shared by all buttons
//   n_btn         : raw asynchronous button, active-low
//   pressed       : registered debounced level
//   press_pulse   : registered strobe on accepted press
//   release_pulse : registered strobe on accepted release
//   long_pulse    : registered strobe once per press after long_press_ms
module button_debounce
   import button_pkg::*;
#(
   parameter int debounce_ms   = 20,
   parameter int long_press_ms = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic n_btn,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int CNT_W = cnt_width(debounce_ms, long_press_ms);
   localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(debounce_ms);
   localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(long_press_ms);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic       sync1_q, sync2_q;
   logic       raw_press;
   btn_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       from_long_q, from_long_d;
   logic       pressed_q, pressed_d;
   logic       press_pulse_q, press_pulse_d;
   logic       release_pulse_q, release_pulse_d;
   logic       long_pulse_q, long_pulse_d;

   // Saturating increment so a very long hold never wraps back to a match.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_ONE;
   endfunction

   assign raw_press = ~sync2_q;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      from_long_d     = from_long_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_pulse_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (raw_press) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!raw_press) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_CNT) begin
               state_d       = ST_HELD;
               cnt_d         = '0;
               press_pulse_d = 1'b1;
            end else if (tick) begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_HELD: begin
            if (!raw_press) begin
               state_d     = ST_RELEASE_WAIT;
               cnt_d       = '0;
               from_long_d = 1'b0;
            end else if (cnt_q == LONG_CNT) begin
               state_d      = ST_LONG_HELD;
               long_pulse_d = 1'b1;
            end else if (tick) begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_LONG_HELD: begin
            if (!raw_press) begin
               state_d     = ST_RELEASE_WAIT;
               cnt_d       = '0;
               from_long_d = 1'b1;
            end
         end
         ST_RELEASE_WAIT: begin
            if (raw_press) begin
               // A bounce back to a long hold must not fire long_pulse again;
               // a bounce back to a plain hold restarts the long-press count.
               if (from_long_q) begin
                  state_d = ST_LONG_HELD;
               end else begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
               end
            end else if (cnt_q == DEB_CNT) begin
               state_d         = ST_IDLE;
               cnt_d           = '0;
               release_pulse_d = 1'b1;
            end else if (tick) begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Level stays asserted through release debounce until the release is accepted.
      pressed_d = (state_d == ST_HELD) || (state_d == ST_LONG_HELD) ||
                  (state_d == ST_RELEASE_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q         <= 1'b1;
         sync2_q         <= 1'b1;
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         from_long_q     <= 1'b0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
      end else begin
         sync1_q         <= n_btn;
         sync2_q         <= sync1_q;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         from_long_q     <= from_long_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_pulse_q    <= long_pulse_d;
      end
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_pulse    = long_pulse_q;

endmodule

// File: rtl/button_reader.sv
// Multi-button reader: shared 1 ms tick generator plus one debouncer per button.
//   clk, rst : system clock, synchronous active-high reset
//   btn_if   : button bundle (slave side) carrying nBtn in and all results out
module button_reader #(
   parameter int ticks_per_second = 27_000_000,
   parameter int num_buttons      = 5,
   parameter int debounce_ms      = 20,
   parameter int long_press_ms    = 1000
) (
   input  logic            clk,
   input  logic            rst,
   button_reader_if.slave  btn_if
);

   localparam logic [31:0] TICK_MAX = 32'(ticks_per_second / 1000 - 1);

   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic        tick;

   logic [num_buttons-1:0] pressed_v;
   logic [num_buttons-1:0] press_pulse_v;
   logic [num_buttons-1:0] release_pulse_v;
   logic [num_buttons-1:0] long_pulse_v;

   always_comb begin
      tick       = (tick_cnt_q == TICK_MAX);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar i = 0; i < num_buttons; i++) begin : g_btn
      button_debounce #(
         .debounce_ms   (debounce_ms),
         .long_press_ms (long_press_ms)
      ) u_debounce (
         .clk           (clk),
         .rst           (rst),
         .tick          (tick),
         .n_btn         (btn_if.nBtn[i]),
         .pressed       (pressed_v[i]),
         .press_pulse   (press_pulse_v[i]),
         .release_pulse (release_pulse_v[i]),
         .long_pulse    (long_pulse_v[i])
      );
   end

   assign btn_if.pressed       = pressed_v;
   assign btn_if.press_pulse   = press_pulse_v;
   assign btn_if.release_pulse = release_pulse_v;
   assign btn_if.long_pulse    = long_pulse_v;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader with 4 kHz clock (1 tick per 4 clk),
// 3 ms debounce, 10 ms long press, 5 buttons.
module tb_button_reader;

   localparam int NB = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_reader_if #(.num_buttons(NB)) bif ();

   button_reader #(
      .ticks_per_second (4000),
      .num_buttons      (NB),
      .debounce_ms      (3),
      .long_press_ms    (10)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_if (bif)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;
   int last_press_cyc = -100000;
   int last_long_cyc  = -100000;

   // Expected strobe events, packed {long, release, press}.
   logic [3*NB-1:0] sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input logic [NB-1:0] l, input logic [NB-1:0] r, input logic [NB-1:0] p);
      sb.push_back({l, r, p});
   endtask

   task automatic wait_pressed(input int idx, input logic lvl, input int budget,
                               input string tag, output int waited);
      waited = 0;
      while (bif.pressed[idx] !== lvl && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      chk(tag, 32'(bif.pressed[idx]), 32'(lvl));
   endtask

   task automatic drain(input string tag, input int budget);
      int w = 0;
      while (sb.size() != 0 && w < budget) begin
         @(negedge clk);
         w++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Every nonzero strobe sample must match the next expected event exactly;
   // a strobe lasting two cycles shows up as an unexpected second event.
   always @(negedge clk) begin : monitor
      logic [3*NB-1:0] ev;
      logic [3*NB-1:0] ex;
      if (mon_en) begin
         ev = {bif.long_pulse, bif.release_pulse, bif.press_pulse};
         if (bif.press_pulse != '0) last_press_cyc = cyc;
         if (bif.long_pulse != '0)  last_long_cyc  = cyc;
         if (ev != '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", 32'(ev), 32'd0);
            end else begin
               ex = sb.pop_front();
               chk("strobe", 32'(ev), 32'(ex));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  stay;
      rst      = 1'b1;
      bif.nBtn = '1;
      repeat (3) @(negedge clk);
      chk("rst_pressed",       32'(bif.pressed),       32'd0);
      chk("rst_press_pulse",   32'(bif.press_pulse),   32'd0);
      chk("rst_release_pulse", 32'(bif.release_pulse), 32'd0);
      chk("rst_long_pulse",    32'(bif.long_pulse),    32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      // Steady press on button 0: accepted after sync + 3 ticks.
      bif.nBtn[0] = 1'b0;
      push_ev('0, '0, 5'b00001);
      wait_pressed(0, 1'b1, 30, "s1_pressed", w);
      chk("s1_press_latency", 32'(w >= 12 && w <= 18), 32'd1);
      drain("s1_press_ev", 5);
      repeat (10) @(negedge clk);
      chk("s1_still_held", 32'(bif.pressed[0]), 32'd1);
      bif.nBtn[0] = 1'b1;
      push_ev('0, 5'b00001, '0);
      wait_pressed(0, 1'b0, 30, "s1_released", w);
      chk("s1_release_latency", 32'(w >= 12 && w <= 18), 32'd1);
      drain("s1_release_ev", 5);

      // Bouncing button 1 (5 clk per level) never settles long enough.
      for (int k = 0; k < 8; k++) begin
         bif.nBtn[1] = ~bif.nBtn[1];
         repeat (5) @(negedge clk);
      end
      bif.nBtn[1] = 1'b1;
      repeat (30) @(negedge clk);
      chk("s2_bounce_pressed", 32'(bif.pressed[1]), 32'd0);

      // 60 clk hold on button 2: one press, one long pulse ~40 clk later, one release.
      last_long_cyc = -100000;
      bif.nBtn[2] = 1'b0;
      push_ev('0, '0, 5'b00100);
      push_ev(5'b00100, '0, '0);
      repeat (60) @(negedge clk);
      chk("s3_held", 32'(bif.pressed[2]), 32'd1);
      chk("s3_long_delay", 32'((last_long_cyc - last_press_cyc) >= 37 &&
                               (last_long_cyc - last_press_cyc) <= 42), 32'd1);
      bif.nBtn[2] = 1'b1;
      push_ev('0, 5'b00100, '0);
      wait_pressed(2, 1'b0, 30, "s3_released", w);
      drain("s3_events", 5);

      // Simultaneous presses on buttons 0 and 4 strobe in the same cycle.
      bif.nBtn[0] = 1'b0;
      bif.nBtn[4] = 1'b0;
      push_ev('0, '0, 5'b10001);
      wait_pressed(4, 1'b1, 30, "s4_pressed4", w);
      chk("s4_both_pressed", 32'(bif.pressed), 32'h11);
      drain("s4_press_ev", 5);
      bif.nBtn[0] = 1'b1;
      bif.nBtn[4] = 1'b1;
      push_ev('0, 5'b10001, '0);
      wait_pressed(4, 1'b0, 30, "s4_released4", w);
      drain("s4_release_ev", 5);

      // Reset while button 3 is held: no release, re-accepted as a new press.
      bif.nBtn[3] = 1'b0;
      push_ev('0, '0, 5'b01000);
      wait_pressed(3, 1'b1, 30, "s5_pressed", w);
      drain("s5_press_ev", 5);
      rst = 1'b1;
      @(negedge clk);
      chk("s5_rst_pressed",       32'(bif.pressed),       32'd0);
      chk("s5_rst_press_pulse",   32'(bif.press_pulse),   32'd0);
      chk("s5_rst_release_pulse", 32'(bif.release_pulse), 32'd0);
      chk("s5_rst_long_pulse",    32'(bif.long_pulse),    32'd0);
      rst = 1'b0;
      push_ev('0, '0, 5'b01000);
      wait_pressed(3, 1'b1, 30, "s5_repressed", w);
      chk("s5_repress_latency", 32'(w >= 12 && w <= 18), 32'd1);
      drain("s5_repress_ev", 5);
      bif.nBtn[3] = 1'b1;
      push_ev('0, 5'b01000, '0);
      wait_pressed(3, 1'b0, 30, "s5_released", w);
      drain("s5_release_ev", 5);

      // 2-tick release glitch while button 1 is held is swallowed.
      bif.nBtn[1] = 1'b0;
      push_ev('0, '0, 5'b00010);
      wait_pressed(1, 1'b1, 30, "s6_pressed", w);
      drain("s6_press_ev", 5);
      stay = 1'b1;
      bif.nBtn[1] = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bif.pressed[1] !== 1'b1) stay = 1'b0;
      end
      bif.nBtn[1] = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bif.pressed[1] !== 1'b1) stay = 1'b0;
      end
      chk("s6_glitch_pressed", 32'(stay), 32'd1);
      bif.nBtn[1] = 1'b1;
      push_ev('0, 5'b00010, '0);
      wait_pressed(1, 1'b0, 30, "s6_released", w);
      drain("s6_release_ev", 5);

      repeat (10) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter ticks_per_second, default 27_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter num_buttons, default 5, the number of push-buttons read.
REQ-003 SHALL have parameter debounce_ms, default 20, the stable time required before a press or release is accepted.
REQ-004 SHALL have parameter long_press_ms, default 1000, the hold time after an accepted press that marks a long press.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port nBtn, input, num_buttons, raw asynchronous buttons, active-low (0 = pressed).
REQ-008 SHALL have port pressed, output, num_buttons, debounced level (1 = held).
REQ-009 SHALL have port press_pulse, output, num_buttons, one-cycle strobe on each accepted press.
REQ-010 SHALL have port release_pulse, output, num_buttons, one-cycle strobe on each accepted release.
REQ-011 SHALL have port long_pulse, output, num_buttons, one-cycle strobe when a press reaches long_press_ms.

Function
REQ-012 SHALL pass each nBtn bit through a 2-flop synchronizer; raw_press = inverted synchronizer output.
REQ-013 SHALL generate a shared 1 ms tick: a 32-bit counter wraps at ticks_per_second/1000 - 1, and tick is high for one cycle at each wrap.
REQ-014 SHALL run one FSM per button with states IDLE, PRESS_WAIT, HELD, LONG_HELD and RELEASE_WAIT, plus a ms counter sized for max(debounce_ms, long_press_ms).
REQ-015 In IDLE, raw_press=1 SHALL move the FSM to PRESS_WAIT and clear the counter.
REQ-016 In PRESS_WAIT, raw_press=0 SHALL return the FSM to IDLE with no output; otherwise each tick increments the counter.
REQ-017 In PRESS_WAIT, when the counter reaches debounce_ms, the FSM SHALL move to HELD, clear the counter, set pressed, and pulse press_pulse.
REQ-018 In HELD, each tick SHALL increment the counter; on reaching long_press_ms the FSM moves to LONG_HELD and pulses long_pulse exactly once per press.
REQ-019 In HELD or LONG_HELD, raw_press=0 SHALL move the FSM to RELEASE_WAIT with the debounce counter cleared, and SHALL remember which held state it came from.
REQ-020 In RELEASE_WAIT, raw_press=1 SHALL return the FSM to the remembered state with no pulse; a press that returns to HELD restarts the long-press count from 0.
REQ-021 In RELEASE_WAIT, when the debounce counter reaches debounce_ms, the FSM SHALL move to IDLE, clear pressed, and pulse release_pulse.
REQ-022 All outputs SHALL be registered; every strobe SHALL be high for exactly one clk cycle, in the cycle after the causing edge.
REQ-023 Buttons SHALL be fully independent; simultaneous events on several bits SHALL produce simultaneous strobes.
REQ-024 Input bounce shorter than debounce_ms SHALL produce no strobe.
REQ-025 The ms counters SHALL saturate and never wrap while held.

Reset
REQ-026 While rst=1, pressed, press_pulse, release_pulse and long_pulse SHALL all be 0.
REQ-027 While rst=1, all FSMs SHALL be in IDLE, all counters 0, and the synchronizer flops 1 (released).
REQ-028 Reset applied mid-press SHALL emit no release_pulse; a button still held after reset SHALL be re-accepted through PRESS_WAIT.

Structure
REQ-029 SHALL place the FSM state enumeration and the counter-width helper function in shared package button_pkg.
REQ-030 SHALL implement the per-button synchronizer, FSM and counter as sub-module button_debounce, instantiated num_buttons times.
REQ-031 The top level SHALL contain the tick generator and the instance array only.

Verification
(All scenarios use ticks_per_second=4000, giving 1 tick per 4 clk; debounce_ms=3; long_press_ms=10; num_buttons=5.)
REQ-032 Hold nBtn[0]=0 steady -> press_pulse[0] is a single cycle after 3 ticks, and pressed[0]=1 within 2+12+4 clk.
REQ-033 Toggle nBtn[1] every 5 clk for 40 clk, then release -> no strobes; pressed[1] stays 0.
REQ-034 Hold nBtn[2] for 60 clk -> exactly one press_pulse and one long_pulse[2] about 40 clk after the press; after release, one release_pulse.
REQ-035 Press nBtn[0] and nBtn[4] on the same cycle -> press_pulse=5'b10001 in a single cycle.
REQ-036 Once pressed[3]=1, assert rst for 1 cycle while the button is held -> all outputs 0, no release_pulse, then a new press_pulse[3] 3 ticks later.
REQ-037 While held, give a 2-tick release glitch -> no release_pulse; pressed stays 1.
